// File: rtl/rtc_pkg.sv
// Shared constants for the RTC read scheduler: slot count, watchdog limit, FSM encoding, address table.
// Latency: n/a (constants and a pure lookup function only).
// Backpressure: n/a.
package rtc_pkg;

  localparam int N_SLOTS     = 11;
  localparam int TIMEOUT_CYC = 255;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RD_ISSUE = 3'd1;
  localparam state_t ST_RD_WAIT  = 3'd2;
  localparam state_t ST_WR_ISSUE = 3'd3;
  localparam state_t ST_WR_WAIT  = 3'd4;

  // RTC register read order for one display frame (slot index -> bus address)
  localparam logic [7:0] ADDR_TBL [0:N_SLOTS-1] = '{
    8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h41, 8'h42, 8'h43, 8'hF0
  };

  // Slot to address lookup; out-of-range slots map to 0 so the bus never sees a stray address
  function automatic logic [7:0] slot_addr(input logic [3:0] slot);
    logic [7:0] a;
    a = 8'h00;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (slot == 4'(i)) a = ADDR_TBL[i];
    end
    return a;
  endfunction

endpackage

// File: rtl/rtc_bus_timeout.sv
// Bus watchdog: counts cycles spent waiting on the transaction engine, saturating at LIMIT.
// Latency: expired is a combinational decode of the count register (count reaches LIMIT LIMIT cycles after clear).
// Backpressure: none; clear wins over enable.
module rtc_bus_timeout #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt;

  // Count wait cycles; restart on every new transaction and hold once the limit is reached
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= 8'd0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/rtc_read_scheduler.sv
// Sequences 11 RTC register reads per refresh tick into the display bank, interleaving user writes between reads.
// Latency: one issue cycle per transaction; capture/ack/frame_valid are combinational in the bus_done cycle.
// Backpressure: waits on bus_done up to TIMEOUT_CYC cycles; one refresh tick is queued while busy, extras dropped.
module rtc_read_scheduler
  import rtc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       bus_start,
  output logic       bus_read,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_done,
  input  logic [7:0] bus_rdata,
  output logic       cap_we,
  output logic [3:0] cap_idx,
  output logic [7:0] cap_data,
  output logic       frame_valid,
  output logic       busy,
  output logic       err
);

  state_t     state, state_nxt;
  logic [3:0] slot;
  logic       tick_pend;
  logic       frame_act;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic       expired;
  logic       in_wait;
  logic       last_slot;
  logic       timeout_hit;
  logic       frame_begin;

  assign in_wait     = (state == ST_RD_WAIT) || (state == ST_WR_WAIT);
  assign last_slot   = (slot == 4'(N_SLOTS - 1));
  assign timeout_hit = in_wait && expired && !bus_done;
  assign frame_begin = (state == ST_IDLE) && (state_nxt == ST_RD_ISSUE);

  rtc_bus_timeout #(
    .LIMIT (8'(TIMEOUT_CYC))
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus_start),
    .enable  (in_wait),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: writes win over reads in IDLE and between read slots
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (wr_req)                         state_nxt = ST_WR_ISSUE;
        else if (refresh_tick || tick_pend) state_nxt = ST_RD_ISSUE;
      end
      ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (bus_done) begin
          if (last_slot)   state_nxt = ST_IDLE;
          else if (wr_req) state_nxt = ST_WR_ISSUE;
          else             state_nxt = ST_RD_ISSUE;
        end else if (expired) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WR_ISSUE: state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (bus_done)     state_nxt = frame_act ? ST_RD_ISSUE : ST_IDLE;
        else if (expired) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame bookkeeping: slot pointer, queued tick, frame-active flag, write operands latched on entry
  always_ff @(posedge clk) begin
    if (reset) begin
      slot      <= 4'd0;
      tick_pend <= 1'b0;
      frame_act <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
    end else begin
      // A tick that cannot start a frame right now (busy, or losing to a write in IDLE) is remembered once
      if (frame_begin) begin
        tick_pend <= 1'b0;
        slot      <= 4'd0;
        frame_act <= 1'b1;
      end else if (refresh_tick) begin
        tick_pend <= 1'b1;
      end

      if ((state_nxt == ST_WR_ISSUE) && (state != ST_WR_ISSUE)) begin
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end

      if ((state == ST_RD_WAIT) && bus_done) begin
        if (last_slot) begin
          slot      <= 4'd0;
          frame_act <= 1'b0;
        end else begin
          slot      <= slot + 4'd1;
        end
      end

      // Any timeout abandons the frame; a pending user write is simply retried from IDLE
      if (timeout_hit) begin
        slot      <= 4'd0;
        frame_act <= 1'b0;
      end
    end
  end

  // Output decode: bus fields held through the wait state, completion strobes gated by bus_done
  always_comb begin
    bus_start   = 1'b0;
    bus_read    = 1'b0;
    bus_addr    = 8'h00;
    bus_wdata   = 8'h00;
    cap_we      = 1'b0;
    cap_idx     = 4'd0;
    cap_data    = 8'h00;
    frame_valid = 1'b0;
    wr_ack      = 1'b0;
    err         = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_RD_ISSUE: begin
        bus_start = 1'b1;
        bus_read  = 1'b1;
        bus_addr  = slot_addr(slot);
      end
      ST_RD_WAIT: begin
        bus_read = 1'b1;
        bus_addr = slot_addr(slot);
        if (bus_done) begin
          cap_we      = 1'b1;
          cap_idx     = slot;
          cap_data    = bus_rdata;
          frame_valid = last_slot;
        end else if (expired) begin
          err = 1'b1;
        end
      end
      ST_WR_ISSUE: begin
        bus_start = 1'b1;
        bus_addr  = wr_addr_q;
        bus_wdata = wr_data_q;
      end
      ST_WR_WAIT: begin
        bus_addr  = wr_addr_q;
        bus_wdata = wr_data_q;
        if (bus_done)     wr_ack = 1'b1;
        else if (expired) err    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
